i2c_burst_writer: RTL and testbench
===================================

Name: i2c_burst_writer

Overview:
Parametrised I2C master write sequencer for display/peripheral initialisation. On a start request it issues START, the slave address byte (write), a control byte (command or data mode), then a burst of `len` payload bytes fetched from an external table, and finally STOP. It retries on NACK and reports done or error status. It drives the same bus-control signals (sda_w, ctrl_d, ctrl_h, ctrl_l) consumed by the existing SCL/SDA pad logic; clk2 is the bit clock.

Parameters:
SLAVE_ADDR, 7'h3D, 7-bit slave address; the address byte is {SLAVE_ADDR,1'b0} = 8'h7A.
ADDR_W, 7, width of the table address, base_addr and len.
MAX_RETRY, 3, retries after NACK before error (total attempts = MAX_RETRY+1).
CTRL_CMD, 8'h00, control byte sent when mode=0.
CTRL_DATA, 8'h40, control byte sent when mode=1.

Ports:
reset  in  1  asynchronous, active-low reset
clk2  in  1  bit clock; one SDA bit per cycle
start  in  1  transaction request; sampled only in IDLE
mode  in  1  0 = command control byte, 1 = data control byte; latched at start
base_addr  in  ADDR_W  first table address; latched at start
len  in  ADDR_W  payload byte count (0 allowed); latched at start
cmd_data  in  8  table read data for cmd_address; combinational, valid in the same cycle
sda  in  1  sampled SDA line (for ACK)
cmd_address  out  ADDR_W  table address (registered)
sda_w  out  1  SDA value when driven
ctrl_d  out  1  1 = master drives SDA, 0 = released
ctrl_h  out  1  SCL control high bit
ctrl_l  out  1  SCL control low bit
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse on successful completion
nack_err  out  1  one-cycle pulse when retries are exhausted

Behaviour:
- Reset (async, active-low):
  - State = IDLE; cmd_address = 0; bit index = 7; retry count = 0.
  - Outputs: done = 0, nack_err = 0, busy = 0, sda_w = 1, ctrl_d = 1, ctrl_h = 1, ctrl_l = 1.
  - Reset mid-transfer aborts immediately to these values. No STOP is generated.
- Output types:
  - sda_w, ctrl_d, ctrl_h, ctrl_l, busy are a Moore decode of the state.
  - done and nack_err are registered pulses.
- Per-state outputs and transitions:
  - IDLE: d=1, sda_w=1, {h,l}=11. If start=1: latch mode/base_addr/len, cmd_address <= base_addr, retry <= 0, go to START.
  - START: d=1, sda_w=0, {h,l}=11. Go to ADDR.
  - ADDR / CTRL / DATA: d=1, {h,l}=00. sda_w = byte[bit], MSB first, 8 cycles each.
    - ADDR sends 8'h7A; CTRL sends CTRL_CMD or CTRL_DATA; DATA sends cmd_data.
    - Bit index counts 7 down to 0. At 0 it reloads 7 and the state moves to the matching ACK state.
  - ACK_A / ACK_C / ACK_D: d=0, sda_w=0, {h,l}=00. Sample sda in this cycle.
    - sda=1 (NACK): go to STOP1 with the failure flag set.
    - ACK_A with ACK: go to CTRL.
    - ACK_C with ACK: go to DATA if len≠0, else STOP1.
    - ACK_D with ACK: cmd_address++ and remaining count--. Go to DATA if bytes remain, else STOP1.
  - STOP1: d=1, sda_w=0, {h,l}=10.
  - STOP2: d=1, sda_w=1, {h,l}=10.
- Exit from STOP2:
  - Success: go to IDLE and pulse done the next cycle.
  - Failure with retry<MAX_RETRY: retry++, cmd_address <= latched base, go straight to START (no IDLE, busy stays high).
  - Failure with retry=MAX_RETRY: go to IDLE and pulse nack_err.
- Timing:
  - Transaction length, START through STOP2, is 21+9·len cycles.
  - start at cycle N puts START at N+1. For len=1: STOP2 at N+30, done at N+31.
- Boundary rules:
  - start while busy is ignored.
  - start held high re-triggers only from IDLE, on the cycle after done.
  - cmd_address wraps modulo 2^ADDR_W.
  - len=0 sends address and control bytes only.
  - done and nack_err are never high together.

Test Plan:
- Reset mid-DATA → outputs at reset values immediately; busy=0; cmd_address=0.
- base=5, len=3, mode=0, always ACK; table[5..7]=A1,B2,C3 → SDA bytes 7A,00,A1,B2,C3 MSB first; cmd_address ends at 8; done at N+49.
- len=0, mode=1 → bytes 7A,40 then STOP; done at N+22; cmd_address unchanged.
- NACK on first ACK_A, then ACK → STOP, START again with cmd_address=base; second attempt completes; done once, nack_err=0.
- Permanent NACK, MAX_RETRY=3 → 4 attempts of 12 cycles each (START through STOP2); nack_err pulse at N+49; done never.
- base=7'h7F, len=2 → fetches 7F then 00; start pulses during busy ignored.

Source files
------------

// File: rtl/i2c_burst_writer.sv
// I2C master write sequencer: START, address, control byte, table burst, STOP.
// Retries the whole transaction on NACK up to MAX_RETRY times.
module i2c_burst_writer #(
    parameter logic [6:0] SLAVE_ADDR = 7'h3D,
    parameter int         ADDR_W     = 7,
    parameter int         MAX_RETRY  = 3,
    parameter logic [7:0] CTRL_CMD   = 8'h00,
    parameter logic [7:0] CTRL_DATA  = 8'h40
) (
    input  logic              reset,
    input  logic              clk2,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] len,
    input  logic [7:0]        cmd_data,
    input  logic              sda,
    output logic [ADDR_W-1:0] cmd_address,
    output logic              sda_w,
    output logic              ctrl_d,
    output logic              ctrl_h,
    output logic              ctrl_l,
    output logic              busy,
    output logic              done,
    output logic              nack_err
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RMAX      = RW'(MAX_RETRY);
    localparam logic [7:0]    ADDR_BYTE = {SLAVE_ADDR, 1'b0};

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_ACK_A,
        S_CTRL,
        S_ACK_C,
        S_DATA,
        S_ACK_D,
        S_STOP1,
        S_STOP2
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [2:0]        bit_idx;
    logic [RW-1:0]     retry;
    logic              fail;
    logic              mode_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] rem;
    logic [7:0]        ctrl_byte;

    assign ctrl_byte = mode_q ? CTRL_DATA : CTRL_CMD;

    always_comb begin
        state_nx = state;
        sda_w    = 1'b1;
        ctrl_d   = 1'b1;
        ctrl_h   = 1'b1;
        ctrl_l   = 1'b1;
        busy     = 1'b1;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nx = S_START;
            end
            S_START: begin
                sda_w    = 1'b0;
                state_nx = S_ADDR;
            end
            S_ADDR: begin
                {ctrl_h, ctrl_l} = 2'b00;
                sda_w = ADDR_BYTE[bit_idx];
                if (bit_idx == 3'd0) state_nx = S_ACK_A;
            end
            S_CTRL: begin
                {ctrl_h, ctrl_l} = 2'b00;
                sda_w = ctrl_byte[bit_idx];
                if (bit_idx == 3'd0) state_nx = S_ACK_C;
            end
            S_DATA: begin
                {ctrl_h, ctrl_l} = 2'b00;
                sda_w = cmd_data[bit_idx];
                if (bit_idx == 3'd0) state_nx = S_ACK_D;
            end
            S_ACK_A, S_ACK_C, S_ACK_D: begin
                {ctrl_h, ctrl_l} = 2'b00;
                ctrl_d = 1'b0;
                sda_w  = 1'b0;
                if (sda)
                    state_nx = S_STOP1;
                else if (state == S_ACK_A)
                    state_nx = S_CTRL;
                else if (state == S_ACK_C)
                    state_nx = (len_q != '0) ? S_DATA : S_STOP1;
                else
                    state_nx = (rem != ADDR_W'(1)) ? S_DATA : S_STOP1;
            end
            S_STOP1: begin
                {ctrl_h, ctrl_l} = 2'b10;
                sda_w    = 1'b0;
                state_nx = S_STOP2;
            end
            S_STOP2: begin
                {ctrl_h, ctrl_l} = 2'b10;
                if (fail && retry < RMAX) state_nx = S_START;
                else                      state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk2 or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            cmd_address <= '0;
            bit_idx     <= 3'd7;
            retry       <= '0;
            fail        <= 1'b0;
            mode_q      <= 1'b0;
            base_q      <= '0;
            len_q       <= '0;
            rem         <= '0;
            done        <= 1'b0;
            nack_err    <= 1'b0;
        end else begin
            state    <= state_nx;
            done     <= 1'b0;
            nack_err <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_q      <= mode;
                        base_q      <= base_addr;
                        len_q       <= len;
                        rem         <= len;
                        cmd_address <= base_addr;
                        retry       <= '0;
                        fail        <= 1'b0;
                    end
                end
                S_ADDR, S_CTRL, S_DATA: begin
                    bit_idx <= (bit_idx == 3'd0) ? 3'd7 : bit_idx - 3'd1;
                end
                S_ACK_A, S_ACK_C: begin
                    if (sda) fail <= 1'b1;
                end
                S_ACK_D: begin
                    if (sda) begin
                        fail <= 1'b1;
                    end else begin
                        cmd_address <= cmd_address + ADDR_W'(1);
                        rem         <= rem - ADDR_W'(1);
                    end
                end
                S_STOP2: begin
                    // a retry restarts the whole burst from the latched base
                    if (!fail) begin
                        done <= 1'b1;
                    end else if (retry < RMAX) begin
                        retry       <= retry + RW'(1);
                        cmd_address <= base_q;
                        rem         <= len_q;
                        fail        <= 1'b0;
                    end else begin
                        nack_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_burst_writer.sv
// Randomised bench for i2c_burst_writer: a transaction-level model expands
// each request into the expected per-cycle bus trace and slave ACK/NACK.
module tb_i2c_burst_writer;

    localparam int AW = 7;
    localparam int MR = 3;

    logic          clk2 = 1'b0;
    logic          reset;
    logic          start;
    logic          mode;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] len;
    logic [7:0]    cmd_data;
    logic          sda;
    logic [AW-1:0] cmd_address;
    logic          sda_w;
    logic          ctrl_d;
    logic          ctrl_h;
    logic          ctrl_l;
    logic          busy;
    logic          done;
    logic          nack_err;

    logic [7:0] tbl [128];
    logic [6:0] exp_q [$];
    logic       sda_q [$];

    int checks = 0;
    int errors = 0;

    i2c_burst_writer dut (
        .reset       (reset),
        .clk2        (clk2),
        .start       (start),
        .mode        (mode),
        .base_addr   (base_addr),
        .len         (len),
        .cmd_data    (cmd_data),
        .sda         (sda),
        .cmd_address (cmd_address),
        .sda_w       (sda_w),
        .ctrl_d      (ctrl_d),
        .ctrl_h      (ctrl_h),
        .ctrl_l      (ctrl_l),
        .busy        (busy),
        .done        (done),
        .nack_err    (nack_err)
    );

    assign cmd_data = tbl[cmd_address];

    always #5 clk2 = ~clk2;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // vector layout: {busy, ctrl_d, sda_w, ctrl_h, ctrl_l, done, nack_err}
    task automatic push(input logic [6:0] v, input logic s);
        exp_q.push_back(v);
        sda_q.push_back(s);
    endtask

    task automatic push_byte(input logic [7:0] by, input logic nack);
        for (int i = 7; i >= 0; i--)
            push({1'b1, 1'b1, by[i], 2'b00, 2'b00}, 1'b0);
        push({1'b1, 1'b0, 1'b0, 2'b00, 2'b00}, nack);
    endtask

    // ack index per attempt: 0 = address, 1 = control, 2+k = data byte k
    task automatic build(input logic [6:0] b, input logic [6:0] n,
                         input logic m, input int plan[4],
                         output logic [6:0] ea);
        bit ok;
        ok = 1'b0;
        ea = b;
        exp_q.delete();
        sda_q.delete();
        for (int a = 0; a <= MR; a++) begin
            int  na;
            int  sent;
            bit  failed;
            na     = plan[a];
            sent   = 0;
            failed = 1'b0;
            push(7'b1_1_0_11_00, 1'b1);
            push_byte(8'h7A, na == 0);
            if (na == 0) failed = 1'b1;
            if (!failed) begin
                push_byte(m ? 8'h40 : 8'h00, na == 1);
                if (na == 1) failed = 1'b1;
            end
            for (int k = 0; k < int'(n) && !failed; k++) begin
                logic [6:0] ad;
                ad = b + 7'(k);
                push_byte(tbl[ad], na == 2 + k);
                if (na == 2 + k) failed = 1'b1;
                else sent++;
            end
            push(7'b1_1_0_10_00, 1'b1);
            push(7'b1_1_1_10_00, 1'b1);
            ea = b + 7'(sent);
            if (!failed) begin
                ok = 1'b1;
                break;
            end
        end
        push({5'b0_1_1_11, ok, !ok}, 1'b1);
        push(7'b0_1_1_11_00, 1'b1);
    endtask

    task automatic run(input logic [6:0] b, input logic [6:0] n,
                       input logic m, input int plan[4], input bit noise);
        logic [6:0] ea;
        int         sz;
        build(b, n, m, plan, ea);
        sz        = exp_q.size();
        start     = 1'b1;
        base_addr = b;
        len       = n;
        mode      = m;
        sda       = 1'b1;
        @(negedge clk2);
        for (int i = 0; i < sz; i++) begin
            chk($sformatf("bus[%0d] b=%0h n=%0d", i, b, n),
                {busy, ctrl_d, sda_w, ctrl_h, ctrl_l, done, nack_err},
                exp_q[i]);
            sda = sda_q[i];
            if (noise && i < sz - 2) begin
                start     = 1'($urandom);
                base_addr = 7'($urandom);
                len       = 7'($urandom);
                mode      = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk2);
        end
        chk($sformatf("addr b=%0h n=%0d", b, n), cmd_address, ea);
    endtask

    initial begin
        int plan [4];
        reset     = 1'b0;
        start     = 1'b0;
        mode      = 1'b0;
        base_addr = '0;
        len       = '0;
        sda       = 1'b1;
        for (int i = 0; i < 128; i++) tbl[i] = 8'($urandom);
        tbl[5]    = 8'hA1;
        tbl[6]    = 8'hB2;
        tbl[7]    = 8'hC3;
        #12;
        chk("reset_out",
            {busy, ctrl_d, sda_w, ctrl_h, ctrl_l, done, nack_err},
            7'b0_1_1_11_00);
        chk("reset_addr", cmd_address, 0);
        @(negedge clk2);
        reset = 1'b1;
        @(negedge clk2);

        run(7'd5, 7'd3, 1'b0, '{-1, -1, -1, -1}, 1'b0);
        run(7'd20, 7'd0, 1'b1, '{-1, -1, -1, -1}, 1'b0);
        run(7'd9, 7'd2, 1'b0, '{0, -1, -1, -1}, 1'b0);
        run(7'd3, 7'd2, 1'b0, '{0, 0, 0, 0}, 1'b0);
        run(7'h7F, 7'd2, 1'b1, '{-1, -1, -1, -1}, 1'b1);
        run(7'd40, 7'd3, 1'b1, '{3, 1, 4, -1}, 1'b1);

        for (int t = 0; t < 25; t++) begin
            logic [6:0] n;
            n = 7'($urandom_range(0, 5));
            for (int a = 0; a < 4; a++)
                plan[a] = ($urandom_range(0, 3) == 0) ?
                          int'($urandom_range(0, int'(n) + 1)) : -1;
            run(7'($urandom), n, 1'($urandom), plan, 1'($urandom));
        end

        // asynchronous reset in the middle of a data byte
        start     = 1'b1;
        base_addr = 7'd10;
        len       = 7'd4;
        sda       = 1'b0;
        @(negedge clk2);
        start = 1'b0;
        repeat (24) @(negedge clk2);
        chk("mid_busy", busy, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("mid_reset_out",
            {busy, ctrl_d, sda_w, ctrl_h, ctrl_l, done, nack_err},
            7'b0_1_1_11_00);
        chk("mid_reset_addr", cmd_address, 0);
        @(negedge clk2);
        reset = 1'b1;
        sda   = 1'b1;
        @(negedge clk2);
        @(negedge clk2);
        chk("post_reset_idle",
            {busy, ctrl_d, sda_w, ctrl_h, ctrl_l, done, nack_err},
            7'b0_1_1_11_00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
